// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: the segment bit order,
// the glyph patterns (active-low) and the special codes. The display encoder
// uses the same constants, so both ends of the bus agree by construction.
package seg7_pkg;

    // Segment bit positions on the bus: seg[0]=a ... seg[6]=g
    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    // Active-low glyph patterns, seg[6:0]
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_ERR   = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Codes for the non-numeric glyphs
    localparam logic [3:0] CODE_ERR   = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Inverse segment map: turns an active-low segment pattern back into its
// 4-bit code. Patterns outside the glyph table are reported as not legal.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] code
);

    // Table lookup; unknown patterns fall to the default arm
    always_comb begin
        legal = 1'b1;
        code  = CODE_BLANK;
        case (seg)
            SEG_0:     code = 4'h0;
            SEG_1:     code = 4'h1;
            SEG_2:     code = 4'h2;
            SEG_3:     code = 4'h3;
            SEG_4:     code = 4'h4;
            SEG_5:     code = 4'h5;
            SEG_6:     code = 4'h6;
            SEG_7:     code = 4'h7;
            SEG_8:     code = 4'h8;
            SEG_9:     code = 4'h9;
            SEG_ERR:   code = CODE_ERR;
            SEG_BLANK: code = CODE_BLANK;
            default: begin
                legal = 1'b0;
                code  = CODE_BLANK;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive-side monitor for a multiplexed 7-segment bus. Synchronizes the
// anode and segment lines, waits for the sampled pair to stay unchanged for
// STABLE_CYCLES cycles, then decodes the pattern into the selected digit's
// code register. Reports frame completion, bad glyphs and bad anode states.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     valid,
    output logic                  frame_done,
    output logic                  err_pattern,
    output logic                  err_anode
);

    localparam int                CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]     CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]     CNT_PRE = CW'(STABLE_CYCLES - 1);
    localparam logic [DIGITS-1:0] ONE_D   = DIGITS'(1);

    // Synchronizer stages and history of the sampled bus
    logic [DIGITS-1:0]   an_meta_r;
    logic [DIGITS-1:0]   an_sync_r;
    logic [6:0]          seg_meta_r;
    logic [6:0]          seg_sync_r;
    logic [DIGITS+6:0]   prev_r;
    logic [CW-1:0]       cnt_r;

    // Captured state
    logic [4*DIGITS-1:0] digits_r;
    logic [DIGITS-1:0]   valid_r;
    logic [DIGITS-1:0]   seen_r;
    logic                frame_done_r;
    logic                err_pattern_r;
    logic                err_anode_r;

    // Combinational helpers
    logic [DIGITS+6:0]   sample_s;
    logic [DIGITS-1:0]   sel_s;
    logic                changed_s;
    logic                any_sel_s;
    logic                multi_sel_s;
    logic                onehot_s;
    logic                capture_s;
    logic [CW-1:0]       cnt_next_s;
    logic                dec_legal_s;
    logic [3:0]          dec_code_s;

    logic [4*DIGITS-1:0] digits_next_s;
    logic [DIGITS-1:0]   valid_next_s;
    logic [DIGITS-1:0]   seen_next_s;
    logic [DIGITS-1:0]   seen_cap_s;
    logic                frame_done_next_s;
    logic                err_pattern_next_s;
    logic                err_anode_next_s;

    assign sample_s    = {an_sync_r, seg_sync_r};
    assign sel_s       = ~an_sync_r;
    assign changed_s   = (sample_s != prev_r);
    assign any_sel_s   = (sel_s != '0);
    // Clearing the lowest set bit leaves something only if two or more were set
    assign multi_sel_s = ((sel_s & (sel_s - ONE_D)) != '0);
    assign onehot_s    = any_sel_s && !multi_sel_s;
    // Capture only on the step that brings the counter up to the threshold
    assign capture_s   = onehot_s && !changed_s && (cnt_r == CNT_PRE);

    seg7_pattern_decode u_decode (
        .seg   (seg_sync_r),
        .legal (dec_legal_s),
        .code  (dec_code_s)
    );

    // Stability counter: restart on any change or non-one-hot anodes, saturate at threshold
    always_comb begin
        cnt_next_s = cnt_r;
        if (changed_s || !onehot_s) begin
            cnt_next_s = '0;
        end else if (cnt_r != CNT_MAX) begin
            cnt_next_s = cnt_r + CW'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Next values of the captured state, with clear taking priority over a capture
    always_comb begin
        digits_next_s      = digits_r;
        valid_next_s       = valid_r;
        seen_next_s        = seen_r;
        seen_cap_s         = seen_r | sel_s;
        frame_done_next_s  = 1'b0;
        err_pattern_next_s = err_pattern_r;
        err_anode_next_s   = err_anode_r | multi_sel_s;
        if (clear) begin
            digits_next_s      = {DIGITS{CODE_BLANK}};
            valid_next_s       = '0;
            seen_next_s        = '0;
            frame_done_next_s  = 1'b0;
            err_pattern_next_s = 1'b0;
            err_anode_next_s   = 1'b0;
        end else if (capture_s) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (sel_s[k]) begin
                    if (dec_legal_s) begin
                        digits_next_s[4*k +: 4] = dec_code_s;
                        valid_next_s[k]         = 1'b1;
                    end else begin
                        digits_next_s[4*k +: 4] = digits_r[4*k +: 4];
                        valid_next_s[k]         = 1'b0;
                    end
                end else begin
                    digits_next_s[4*k +: 4] = digits_r[4*k +: 4];
                end
            end
            if (!dec_legal_s) begin
                err_pattern_next_s = 1'b1;
            end else begin
                err_pattern_next_s = err_pattern_r;
            end
            if (&seen_cap_s) begin
                frame_done_next_s = 1'b1;
                seen_next_s       = '0;
            end else begin
                seen_next_s       = seen_cap_s;
            end
        end else begin
            digits_next_s = digits_r;
        end
    end

    // Input synchronizers, previous-sample history and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta_r  <= '1;
            an_sync_r  <= '1;
            seg_meta_r <= 7'h7F;
            seg_sync_r <= 7'h7F;
            prev_r     <= '1;
            cnt_r      <= '0;
        end else begin
            an_meta_r  <= an;
            an_sync_r  <= an_meta_r;
            seg_meta_r <= seg;
            seg_sync_r <= seg_meta_r;
            prev_r     <= sample_s;
            if (clear) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_next_s;
            end
        end
    end

    // Captured codes, validity, frame tracking and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_r      <= {DIGITS{CODE_BLANK}};
            valid_r       <= '0;
            seen_r        <= '0;
            frame_done_r  <= 1'b0;
            err_pattern_r <= 1'b0;
            err_anode_r   <= 1'b0;
        end else begin
            digits_r      <= digits_next_s;
            valid_r       <= valid_next_s;
            seen_r        <= seen_next_s;
            frame_done_r  <= frame_done_next_s;
            err_pattern_r <= err_pattern_next_s;
            err_anode_r   <= err_anode_next_s;
        end
    end

    assign digits      = digits_r;
    assign valid       = valid_r;
    assign frame_done  = frame_done_r;
    assign err_pattern = err_pattern_r;
    assign err_anode   = err_anode_r;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with DIGITS=4, STABLE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_seg7_scan_capture;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        clear;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        frame_done;
    logic        err_pattern;
    logic        err_anode;

    int checks;
    int errors;
    int fd_cnt;

    seg7_scan_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .clear       (clear),
        .digits      (digits),
        .valid       (valid),
        .frame_done  (frame_done),
        .err_pattern (err_pattern),
        .err_anode   (err_anode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_done pulses away from the active edge
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        step(n);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        an    = 4'b1111;
        seg   = 7'h7F;
        clear = 1'b0;
        #23;
        rst_n = 1'b1;
        step(10);
        checks++;
        if (digits !== 16'hFFFF) begin errors++; $display("FAIL reset_digits: got %h want ffff", digits); end
        checks++;
        if (valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b want 0000", valid); end
        checks++;
        if ({err_pattern, err_anode} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b want 00", {err_pattern, err_anode}); end
        checks++;
        if (fd_cnt !== 0) begin errors++; $display("FAIL reset_frame: got %0d pulses want 0", fd_cnt); end
    endtask

    task automatic test_latency();
        an  = 4'b1110;
        seg = 7'h24;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (i == 6) begin
                checks++;
                if (valid !== 4'b0000) begin errors++; $display("FAIL latency_early: got %b want 0000 at edge 6", valid); end
            end
            if (i == 7) begin
                checks++;
                if (valid !== 4'b0001 || digits !== 16'hFFF2) begin
                    errors++; $display("FAIL latency_edge7: got valid=%b digits=%h want 0001 fff2", valid, digits);
                end
            end
        end
        checks++;
        if (valid !== 4'b0001 || digits !== 16'hFFF2 || fd_cnt !== 0) begin
            errors++; $display("FAIL latency_hold: got valid=%b digits=%h fd=%0d want 0001 fff2 0", valid, digits, fd_cnt);
        end
    endtask

    task automatic test_scan();
        hold(4'b1110, 7'h79, 10);
        hold(4'b1101, 7'h30, 10);
        hold(4'b1011, 7'h06, 10);
        checks++;
        if (fd_cnt !== 0) begin errors++; $display("FAIL scan_no_early_frame: got %0d want 0", fd_cnt); end
        an  = 4'b0111;
        seg = 7'h7F;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (i == 7) begin
                checks++;
                if (frame_done !== 1'b1) begin errors++; $display("FAIL scan_frame_pulse: got %b want 1", frame_done); end
            end
            if (i == 8) begin
                checks++;
                if (frame_done !== 1'b0) begin errors++; $display("FAIL scan_frame_one_cycle: got %b want 0", frame_done); end
            end
        end
        checks++;
        if (digits !== 16'hFE31 || valid !== 4'hF) begin
            errors++; $display("FAIL scan_result: got digits=%h valid=%h want fe31 f", digits, valid);
        end
        checks++;
        if (fd_cnt !== 1) begin errors++; $display("FAIL scan_frame_count: got %0d want 1", fd_cnt); end
    endtask

    task automatic test_bad_pattern();
        hold(4'b1101, 7'h55, 10);
        checks++;
        if (err_pattern !== 1'b1 || valid !== 4'b1101 || digits !== 16'hFE31) begin
            errors++; $display("FAIL bad_pattern: got err=%b valid=%b digits=%h want 1 1101 fe31", err_pattern, valid, digits);
        end
        hold(4'b1111, 7'h7F, 5);
        checks++;
        if (err_pattern !== 1'b1) begin errors++; $display("FAIL bad_pattern_sticky: got %b want 1", err_pattern); end
        pulse_clear();
        checks++;
        if (err_pattern !== 1'b0 || digits !== 16'hFFFF || valid !== 4'b0000) begin
            errors++; $display("FAIL bad_pattern_clear: got err=%b digits=%h valid=%b want 0 ffff 0000", err_pattern, digits, valid);
        end
    endtask

    task automatic test_anode_and_glitch();
        hold(4'b1100, 7'h24, 10);
        checks++;
        if (err_anode !== 1'b1 || valid !== 4'b0000 || digits !== 16'hFFFF) begin
            errors++; $display("FAIL multi_anode: got err=%b valid=%b digits=%h want 1 0000 ffff", err_anode, valid, digits);
        end
        hold(4'b1111, 7'h7F, 3);
        pulse_clear();
        checks++;
        if (err_anode !== 1'b0) begin errors++; $display("FAIL multi_anode_clear: got %b want 0", err_anode); end
        for (int k = 0; k < 10; k++) begin
            hold(4'b1110, (k % 2 == 1) ? 7'h30 : 7'h24, 3);
        end
        hold(4'b1111, 7'h7F, 8);
        checks++;
        if (valid !== 4'b0000 || digits !== 16'hFFFF || err_pattern !== 1'b0) begin
            errors++; $display("FAIL short_glitch: got valid=%b digits=%h errp=%b want 0000 ffff 0", valid, digits, err_pattern);
        end
    endtask

    task automatic test_clear_on_capture();
        an  = 4'b1110;
        seg = 7'h79;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            if (i == 6) clear = 1'b1;
        end
        clear = 1'b0;
        an    = 4'b1111;
        seg   = 7'h7F;
        checks++;
        if (valid !== 4'b0000 || digits !== 16'hFFFF) begin
            errors++; $display("FAIL clear_on_capture: got valid=%b digits=%h want 0000 ffff", valid, digits);
        end
        step(10);
        checks++;
        if (valid !== 4'b0000 || digits !== 16'hFFFF) begin
            errors++; $display("FAIL clear_on_capture_after: got valid=%b digits=%h want 0000 ffff", valid, digits);
        end
    endtask

    task automatic test_reset_mid();
        hold(4'b0111, 7'h19, 10);
        checks++;
        if (valid !== 4'b1000 || digits !== 16'h4FFF) begin
            errors++; $display("FAIL pre_reset_capture: got valid=%b digits=%h want 1000 4fff", valid, digits);
        end
        an  = 4'b1101;
        seg = 7'h12;
        step(4);
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid !== 4'b0000 || digits !== 16'hFFFF || frame_done !== 1'b0) begin
            errors++; $display("FAIL async_reset: got valid=%b digits=%h fd=%b want 0000 ffff 0", valid, digits, frame_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step(1);
            if (i == 6) begin
                checks++;
                if (valid !== 4'b0000) begin errors++; $display("FAIL reset_recapture_early: got %b want 0000", valid); end
            end
            if (i == 7) begin
                checks++;
                if (valid !== 4'b0010 || digits !== 16'hFF5F) begin
                    errors++; $display("FAIL reset_recapture: got valid=%b digits=%h want 0010 ff5f", valid, digits);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fd_cnt = 0;
        test_reset();
        test_latency();
        test_scan();
        test_bad_pattern();
        test_anode_and_glitch();
        test_clear_on_capture();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
Receive-side monitor for the multiplexed 7-segment display bus: watches the active-low anode scan lines and active-low segment lines and recovers each digit's 4-bit code by inverse-mapping the segment pattern.
Captures a digit only once its pattern has been stable, and keeps one code register per digit position.
Flags illegal patterns and illegal anode combinations.
Used on-board as a loopback checker for the display path and as a scoreboard source in simulation.

Parameters:
DIGITS, 4, number of multiplexed digit positions (1..8)
STABLE_CYCLES, 4, consecutive identical synchronized samples required before capture (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
an  in  DIGITS  anode enables, active-low; bit k low selects digit k
seg  in  7  segment lines, active-low; seg[0]=a ... seg[6]=g
clear  in  1  synchronous clear of captured state and error flags
digits  out  4*DIGITS  captured codes; digit k occupies digits[4k+3:4k]
valid  out  DIGITS  bit k set = digits[k] holds a legally decoded pattern
frame_done  out  1  one-cycle pulse when every position has been captured since the last pulse
err_pattern  out  1  sticky; an unrecognised pattern was captured
err_anode  out  1  sticky; more than one anode was low on a synchronized sample

Behaviour:
- Reset values: digits all 4'hF, valid 0, frame_done 0, err_pattern 0, err_anode 0.
- Internal state reset values: synchronizers all-ones, stability counter 0, seen mask 0.
- Sync: an and seg each pass through a 2-flop synchronizer before any use.
- Stability counter:
  - Compare the synchronized {an,seg} with its value on the previous cycle.
  - Counter clears when the value changed, or when an is not exactly one-hot-low.
  - Otherwise it increments, saturating at STABLE_CYCLES.
- Capture: happens in the single cycle the counter reaches STABLE_CYCLES. One capture per stable interval; holding inputs does not re-capture.
- Latency: with inputs held, the digits/valid update is visible exactly STABLE_CYCLES+3 rising edges after the input change.
- Decode table, seg[6:0] -> code:
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9
  - 06->E (error glyph)
  - 7F->F (blank)
  - All of these are legal: write the code to digits[k], set valid[k], set seen[k].
- Any other pattern on capture: digits[k] keeps its old value, valid[k] clears, seen[k] sets, err_pattern sets.
- an all-ones (no digit driven): counter clears, no error, no capture.
- Two or more an bits low: err_anode sets, counter clears, no capture.
- Frame completion: if a capture makes seen all-ones, frame_done pulses that same registered cycle and seen clears to 0 in that cycle.
- Repeated capture of the same position before the frame completes: overwrites digits[k], frame_done does not pulse.
- clear=1:
  - Digits go to all F; valid, seen, both errors and the counter go to 0. frame_done is 0 that cycle.
  - clear has priority over a simultaneous capture; the capture is lost.
- rst_n asserted mid-capture: all state returns to reset values immediately. The first capture after release needs a full new stable interval.
- Counter width is clog2(STABLE_CYCLES+1). Never wraps.

Decomposition:
- Package seg7_pkg holds:
  - Pattern constants SEG_0..SEG_9, SEG_ERR=7'h06, SEG_BLANK=7'h7F.
  - Codes CODE_ERR=4'hE, CODE_BLANK=4'hF.
  - The segment bit-order definition.
  - These constants are shared with the display encoder.
- One combinational sub-module, seg7_pattern_decode: seg[6:0] -> {legal, code[3:0]}.
- Synchronizers, counter, capture registers and the frame logic stay in the top module.

Test Plan:
- Reset, then idle with an=all-ones -> digits=16'hFFFF, valid=0, no flags, no frame_done.
- DIGITS=4, STABLE_CYCLES=4; an=4'b1110, seg=7'h24 held 20 cycles -> digits[3:0]=2 and valid=4'b0001 exactly 7 edges after change; a single capture.
- Scan an through 1110, 1101, 1011, 0111 with seg 79, 30, 06, 7F, 10 cycles each -> digits=16'hFE31, valid=4'hF, one frame_done pulse on the 4th capture.
- seg=7'h55 on digit 1, stable -> err_pattern=1 sticky, valid[1]=0, digits[7:4] unchanged; then clear -> err_pattern=0, digits=16'hFFFF.
- an=4'b1100 held -> err_anode=1, no capture. Also: seg toggling every 3 cycles (less than STABLE_CYCLES) -> no capture.
- clear asserted on the capture cycle -> capture dropped, valid=0. rst_n pulsed low mid-interval -> outputs at reset values, next capture only after a full STABLE_CYCLES+3 edges.
